// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the synchronous FIFO slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count
//   level_width()                 : bits needed to count 0..DEPTH inclusive
//   fifo_op_e                     : per-cycle accepted-operation encoding
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 16;

    // One extra bit over the address width so that a completely full FIFO
    // (level == DEPTH) is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
// Handshake/data bundle between a FIFO user (master) and the FIFO (slave).
//   i_wren, i_wdata        : write request and data (master -> slave)
//   i_rden                 : read request (master -> slave)
//   o_rdata                : read data (slave -> master)
//   o_empty, o_full        : level == 0 / level == DEPTH
//   o_almost_empty/full    : level <= AE threshold / level >= AF threshold
//   o_level                : current occupancy
//   o_overflow/underflow   : one-cycle error pulses
// ---------------------------------------------------------------------------
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);

    localparam int LW = level_width(DEPTH);

    logic             i_wren;
    logic [WIDTH-1:0] i_wdata;
    logic             i_rden;
    logic [WIDTH-1:0] o_rdata;
    logic             o_empty;
    logic             o_full;
    logic             o_almost_empty;
    logic             o_almost_full;
    logic [LW-1:0]    o_level;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_wren,
        output i_wdata,
        output i_rden,
        input  o_rdata,
        input  o_empty,
        input  o_full,
        input  o_almost_empty,
        input  o_almost_full,
        input  o_level,
        input  o_overflow,
        input  o_underflow
    );

    modport slave (
        input  i_wren,
        input  i_wdata,
        input  i_rden,
        output o_rdata,
        output o_empty,
        output o_full,
        output o_almost_empty,
        output o_almost_full,
        output o_level,
        output o_overflow,
        output o_underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port, no reset (contents survive a FIFO reset; only pointers clear).
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data at rd_addr
// ---------------------------------------------------------------------------
module sync_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parameterised single-clock FIFO with level, almost-full/empty flags and
// overflow/underflow pulses.
//   i_clk : clock, all logic on rising edge
//   i_rst : asynchronous active-high reset
//   bus   : sync_fifo_param_if slave (write/read handshake, data, status)
// Build option:
//   SYNC_FIFO_FWFT_EN defined   -> first-word-fall-through: o_rdata shows
//                                  the head entry combinationally
//   SYNC_FIFO_FWFT_EN undefined -> o_rdata registered, popped word appears
//                                  the cycle after an accepted read
// ---------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    sync_fifo_param_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] ram_rdata;
    fifo_op_e         op;

    // Status flags come straight from the registered level.
    always_comb begin
        empty        = (level == '0);
        full         = (level == LW'(DEPTH));
        almost_empty = (int'(level) <= AE_THRESH);
        almost_full  = (int'(level) >= AF_THRESH);
    end

    // A write into a full FIFO is still accepted when a read frees a slot in
    // the same cycle; a read from an empty FIFO is never accepted.
    always_comb begin
        rd_acc = bus.i_rden && !empty;
        wr_acc = bus.i_wren && (!full || rd_acc);
        op     = fifo_op_e'({wr_acc, rd_acc});
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case (op)
                OP_WRITE: level <= level + LW'(1);
                OP_READ:  level <= level - LW'(1);
                default:  level <= level;
            endcase
            overflow  <= bus.i_wren && full && !rd_acc;
            // A simultaneous write into an empty FIFO is not an underflow.
            underflow <= bus.i_rden && empty && !bus.i_wren;
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (bus.i_wdata),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is visible whenever the FIFO is non-empty; when empty the
    // stale array word at rd_ptr is shown and stays stable.
    assign bus.o_rdata = ram_rdata;
`else
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= ram_rdata;
        end
    end

    assign bus.o_rdata = rdata_q;
`endif

    assign bus.o_empty        = empty;
    assign bus.o_full         = full;
    assign bus.o_almost_empty = almost_empty;
    assign bus.o_almost_full  = almost_full;
    assign bus.o_level        = level;
    assign bus.o_overflow     = overflow;
    assign bus.o_underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (WIDTH=32, DEPTH=8, AF=6, AE=2).
// A queue-based reference model tracks contents and expected status; both
// read modes are handled depending on SYNC_FIFO_FWFT_EN.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sync_fifo_param #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int test_count = 0;
    int fail_count = 0;

    logic [W-1:0] model_q [$];
    logic [W-1:0] exp_rdata;
    logic         exp_overflow;
    logic         exp_underflow;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        model_q.delete();
        exp_rdata     = '0;
        exp_overflow  = 1'b0;
        exp_underflow = 1'b0;
    endfunction

    // Behaviour of one rising edge, derived from occupancy rules only.
    function automatic void modelStep(input logic wren, input logic [W-1:0] wdata,
                                      input logic rden);
        int  sz;
        logic rd_ok;
        logic wr_ok;
        sz            = model_q.size();
        rd_ok         = rden && (sz > 0);
        wr_ok         = wren && ((sz < D) || rd_ok);
        exp_overflow  = wren && (sz == D) && !rd_ok;
        exp_underflow = rden && (sz == 0) && !wren;
        if (rd_ok) exp_rdata = model_q.pop_front();
        if (wr_ok) model_q.push_back(wdata);
    endfunction

    task automatic compareState(input string tag);
        int sz;
        sz = model_q.size();
        checkOutput({tag, "_level"}, 32'(bus.o_level), 32'(sz));
        checkOutput({tag, "_empty"}, 32'(bus.o_empty), 32'(sz == 0));
        checkOutput({tag, "_full"}, 32'(bus.o_full), 32'(sz == D));
        checkOutput({tag, "_aempty"}, 32'(bus.o_almost_empty), 32'(sz <= AE));
        checkOutput({tag, "_afull"}, 32'(bus.o_almost_full), 32'(sz >= AF));
        checkOutput({tag, "_ovf"}, 32'(bus.o_overflow), 32'(exp_overflow));
        checkOutput({tag, "_unf"}, 32'(bus.o_underflow), 32'(exp_underflow));
`ifdef SYNC_FIFO_FWFT_EN
        if (sz > 0) checkOutput({tag, "_rdata"}, bus.o_rdata, model_q[0]);
`else
        checkOutput({tag, "_rdata"}, bus.o_rdata, exp_rdata);
`endif
    endtask

    // Drive one cycle of requests, advance the model on the edge and compare
    // 1 time unit after the edge.
    task automatic applyStimulus(input string tag, input logic wren,
                                 input logic [W-1:0] wdata, input logic rden);
        bus.i_wren  = wren;
        bus.i_wdata = wdata;
        bus.i_rden  = rden;
        @(posedge clk);
        modelStep(wren, wdata, rden);
        #1;
        bus.i_wren = 1'b0;
        bus.i_rden = 1'b0;
        compareState(tag);
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        bus.i_wren = 1'b0;
        bus.i_rden = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();
        compareState("reset");
        rst = 1'b0;
    endtask

    initial begin
        bus.i_wren  = 1'b0;
        bus.i_rden  = 1'b0;
        bus.i_wdata = '0;
        modelReset();

        applyReset();

        // Fill 0..7, then one write too many.
        for (int i = 0; i < D; i++) applyStimulus("fill", 1'b1, 32'(i), 1'b0);
        applyStimulus("overflow", 1'b1, 32'h99, 1'b0);
        applyStimulus("after_ovf", 1'b0, '0, 1'b0);

        // Drain in order, then one read too many.
        for (int i = 0; i < D; i++) applyStimulus("drain", 1'b0, '0, 1'b1);
        applyStimulus("underflow", 1'b0, '0, 1'b1);
        applyStimulus("after_unf", 1'b0, '0, 1'b0);

        // Simultaneous read and write while full.
        for (int i = 0; i < D; i++) applyStimulus("fill2", 1'b1, 32'h100 + 32'(i), 1'b0);
        applyStimulus("full_rw", 1'b1, 32'hABCD, 1'b1);
        for (int i = 0; i < D; i++) applyStimulus("drain2", 1'b0, '0, 1'b1);

        // Simultaneous read and write while empty.
        applyStimulus("empty_rw", 1'b1, 32'h5A5A, 1'b1);
        applyStimulus("empty_rw_rd", 1'b0, '0, 1'b1);
        applyStimulus("idle", 1'b0, '0, 1'b0);

        // Asynchronous reset at level 5.
        for (int i = 0; i < 5; i++) applyStimulus("pre_rst", 1'b1, 32'h200 + 32'(i), 1'b0);
        rst = 1'b1;
        #1;
        modelReset();
        compareState("async_rst");
        @(posedge clk);
        #1;
        compareState("rst_hold");
        rst = 1'b0;
        applyStimulus("post_rst", 1'b1, 32'h300, 1'b0);
        applyStimulus("post_rst_rd", 1'b0, '0, 1'b1);

        // Random traffic: write-heavy phase then read-heavy phase so both
        // full and empty boundaries and pointer wrap are exercised.
        for (int c = 0; c < 2000; c++) begin
            logic wr;
            logic rd;
            if (c < 1000) begin
                wr = ($urandom_range(0, 99) < 65);
                rd = ($urandom_range(0, 99) < 45);
            end else begin
                wr = ($urandom_range(0, 99) < 45);
                rd = ($urandom_range(0, 99) < 65);
            end
            applyStimulus("rand", wr, $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
